// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and sizing helpers.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultSize  = 8;
    localparam int unsigned DefaultDigit = 2;

    function automatic int unsigned calc_nsteps(int unsigned size, int unsigned digit);
        return size / digit;
    endfunction

    // Wide enough to hold NSTEPS itself, not just NSTEPS-1.
    function automatic int unsigned calc_cnt_width(int unsigned size, int unsigned digit);
        return $clog2(calc_nsteps(size, digit)) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_digit_sub.sv
// Combinational DIGIT-wide ripple-borrow subtractor built from single-bit full subtractors.
module digit_sub
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fs
        assign d[i]          = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = x - y, DIGIT bits per clock, registered borrow chain.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned SIZE  = DefaultSize,
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout,
    output logic            busy
);

    localparam int unsigned NSteps = calc_nsteps(SIZE, DIGIT);
    localparam int unsigned CntW   = calc_cnt_width(SIZE, DIGIT);

    state_e state_q, state_d;

    logic [SIZE-1:0]  x_q, x_d;
    logic [SIZE-1:0]  y_q, y_d;
    logic [SIZE-1:0]  diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;
    logic             accept;
    logic             last_step;

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_digit_sub (
        .a   (x_q[DIGIT-1:0]),
        .b   (y_q[DIGIT-1:0]),
        .bin (borrow_q),
        .d   (dig_d),
        .bout(dig_bout)
    );

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == CntW'(NSteps - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        if (accept) begin
            x_d      = x;
            y_d      = y;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == StRun) begin
            x_d      = x_q >> DIGIT;
            y_d      = y_q >> DIGIT;
            // New digit enters at the MSB end so the LSB digit lands at bit 0 after NSTEPS shifts.
            diff_d   = (diff_q >> DIGIT) | (SIZE'(dig_d) << (SIZE - DIGIT));
            borrow_d = dig_bout;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign diff = diff_q;
    assign bout = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases on DIGIT=2, random vectors on DIGIT=8 and DIGIT=1 builds.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] xs        [3];
    logic [7:0] ys        [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] diffs     [3];
    logic       bouts     [3];
    logic       busys     [3];

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.SIZE(8), .DIGIT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(xs[0]), .y(ys[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .diff(diffs[0]), .bout(bouts[0]), .busy(busys[0])
    );

    serial_subtractor #(.SIZE(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(xs[1]), .y(ys[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .diff(diffs[1]), .bout(bouts[1]), .busy(busys[1])
    );

    serial_subtractor #(.SIZE(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(xs[2]), .y(ys[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .diff(diffs[2]), .bout(bouts[2]), .busy(busys[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular subtraction and unsigned compare.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input int hold);
        int         lat;
        logic [7:0] ed;
        logic       eb;
        ed = a - b;
        eb = (a < b);
        in_valid[k] = 1'b1;
        xs[k] = a;
        ys[k] = b;
        check("in_ready_idle", 32'(in_ready[k]), 1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        check("busy_run", 32'(busys[k]), 1);
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            check("in_ready_run", 32'(in_ready[k]), 0);
            xs[k] = 8'($urandom);
            ys[k] = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("diff", 32'(diffs[k]), 32'(ed));
        check("bout", 32'(bouts[k]), 32'(eb));
        for (int h = 0; h < hold; h++) begin
            in_valid[k] = 1'b1;
            xs[k] = 8'($urandom);
            ys[k] = 8'($urandom);
            @(posedge clk); #1;
            check("hold_diff", 32'(diffs[k]), 32'(ed));
            check("hold_bout", 32'(bouts[k]), 32'(eb));
            check("hold_in_ready", 32'(in_ready[k]), 0);
            check("hold_out_valid", 32'(out_valid[k]), 1);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("out_valid_clr", 32'(out_valid[k]), 0);
        check("in_ready_back", 32'(in_ready[k]), 1);
        check("busy_idle", 32'(busys[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            xs[k]        = '0;
            ys[k]        = '0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 32'(in_ready[k]), 1);
            check("rst_out_valid", 32'(out_valid[k]), 0);
            check("rst_busy", 32'(busys[k]), 0);
            check("rst_diff", 32'(diffs[k]), 0);
            check("rst_bout", 32'(bouts[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 8'h5A, 8'h23, 4, 0);
        run_op(0, 8'h10, 8'h20, 4, 0);
        run_op(0, 8'h00, 8'h01, 4, 0);
        run_op(0, 8'hFF, 8'hFF, 4, 0);
        // Backpressure with ignored in_valid pulses while DONE.
        run_op(0, 8'h33, 8'h7C, 4, 5);

        // Abort mid-RUN with a pending borrow, then confirm no stale borrow leaks.
        in_valid[0] = 1'b1;
        xs[0] = 8'h00;
        ys[0] = 8'hFF;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid[0]), 0);
        check("abort_in_ready", 32'(in_ready[0]), 1);
        check("abort_busy", 32'(busys[0]), 0);
        check("abort_bout", 32'(bouts[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 8'h80, 8'h01, 4, 0);

        for (int i = 0; i < 50; i++) begin
            run_op(0, 8'($urandom), 8'($urandom), 4, int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 1000; i++) begin
            run_op(1, 8'($urandom), 8'($urandom), 1, int'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 1000; i++) begin
            run_op(2, 8'($urandom), 8'($urandom), 8, int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
